// File: rtl/timing_sequencer_pkg.sv
// Shared control definitions for the timing sequencer: T-state indices,
// bit-ordering helpers and the per-edge step action encoding.
package timing_sequencer_pkg;

    localparam int T0  = 0;
    localparam int T1  = 1;
    localparam int T2  = 2;
    localparam int T3  = 3;
    localparam int T4  = 4;
    localparam int T5  = 5;
    localparam int T6  = 6;
    localparam int T7  = 7;
    localparam int T8  = 8;
    localparam int T9  = 9;
    localparam int T10 = 10;
    localparam int T11 = 11;
    localparam int T12 = 12;
    localparam int T13 = 13;
    localparam int T14 = 14;
    localparam int T15 = 15;
    localparam int T16 = 16;
    localparam int T17 = 17;
    localparam int T18 = 18;
    localparam int T19 = 19;
    localparam int T20 = 20;
    localparam int T21 = 21;
    localparam int T22 = 22;
    localparam int T23 = 23;
    localparam int T24 = 24;
    localparam int T25 = 25;
    localparam int T26 = 26;
    localparam int T27 = 27;
    localparam int T28 = 28;
    localparam int T29 = 29;
    localparam int T30 = 30;
    localparam int T31 = 31;

    localparam bit ORDER_MSB_FIRST = 1'b1;
    localparam bit ORDER_LSB_FIRST = 1'b0;

    // Physical bit position of T-state 'step', so control equations can name
    // T-states by index regardless of the chosen ordering.
    function automatic int t_line(input int step, input int n_steps, input bit reverse);
        return reverse ? (n_steps - 1 - step) : step;
    endfunction

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_ADVANCE,
        ACT_WRAP,
        ACT_CLEAR
    } step_action_e;

endpackage

// File: rtl/timing_sequencer_if.sv
// Control/timing bundle between the control unit (master) and the sequencer (slave).
interface timing_sequencer_if #(
    parameter int N_STEPS = 32
);
    import timing_sequencer_pkg::*;

    localparam int CNT_W = $clog2(N_STEPS);

    logic               en;
    logic               clr;
    logic [CNT_W-1:0]   end_step;
    logic [N_STEPS-1:0] t;
    logic [CNT_W-1:0]   step;
    logic               last;
    logic               wrap;

    modport master (
        output en, clr, end_step,
        input  t, step, last, wrap
    );

    modport slave (
        input  en, clr, end_step,
        output t, step, last, wrap
    );

endinterface

// File: rtl/timing_sequencer_onehot_decoder.sv
// Combinational binary-to-one-hot decoder with selectable bit ordering;
// codes at or beyond WIDTH decode to all zeros like the legacy decoder.
module onehot_decoder
    import timing_sequencer_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int IN_W    = 5,
    parameter bit REVERSE = ORDER_MSB_FIRST
) (
    input  logic [IN_W-1:0]  sel,
    output logic [WIDTH-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (sel == IN_W'(k)) begin
                onehot[t_line(k, WIDTH, REVERSE)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timing_sequencer.sv
// Timing-step generator: registered step counter with stall, restart and a
// per-instruction end step, decoded into one-hot T-state lines.
module timing_sequencer
    import timing_sequencer_pkg::*;
#(
    parameter int N_STEPS = 32,
    parameter bit REVERSE = ORDER_MSB_FIRST
) (
    input  logic                clk,
    input  logic                rst,
    timing_sequencer_if.slave   bus
);

    localparam int CNT_W = $clog2(N_STEPS);
    localparam logic [CNT_W-1:0] MAX_STEP = CNT_W'(N_STEPS - 1);

    logic [CNT_W-1:0] step_q;
    logic [CNT_W-1:0] step_d;
    logic [CNT_W-1:0] eff_end;
    logic             wrap_q;
    logic             wrap_d;
    logic             last;
    step_action_e     action;

    // Clamping the end step keeps the counter inside 0..N_STEPS-1 even when a
    // non-power-of-two step count leaves unused binary codes.
    always_comb begin
        eff_end = (bus.end_step > MAX_STEP) ? MAX_STEP : bus.end_step;
    end

    assign last = (step_q >= eff_end);

    always_comb begin
        action = ACT_HOLD;
        step_d = step_q;
        wrap_d = 1'b0;
        if (bus.clr) begin
            action = ACT_CLEAR;
        end else if (bus.en && last) begin
            action = ACT_WRAP;
        end else if (bus.en) begin
            action = ACT_ADVANCE;
        end
        unique case (action)
            ACT_CLEAR:   step_d = '0;
            ACT_WRAP: begin
                step_d = '0;
                wrap_d = 1'b1;
            end
            ACT_ADVANCE: step_d = step_q + CNT_W'(1);
            default:     step_d = step_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    onehot_decoder #(
        .WIDTH   (N_STEPS),
        .IN_W    (CNT_W),
        .REVERSE (REVERSE)
    ) u_decoder (
        .sel    (step_q),
        .onehot (bus.t)
    );

    assign bus.step = step_q;
    assign bus.last = last;
    assign bus.wrap = wrap_q;

endmodule

// File: doc/timing_sequencer.md
Name: timing_sequencer

Overview:
- Parametrised timing-step generator for the hardwired control unit. A registered step counter drives a one-hot decoder that produces the T-state lines (T0..T(N-1)) consumed by the control logic.
- Extends the fixed 5-to-32 decode with:
  - configurable step count;
  - selectable bit ordering;
  - per-instruction end step;
  - advance enable (stall);
  - synchronous restart.

Parameters:
- N_STEPS, 32, number of timing steps / one-hot output width; legal range 2..64.
- CNT_W, $clog2(N_STEPS), step counter width; derived, never overridden.
- REVERSE, 1, 1: step k drives T[N_STEPS-1-k] (T0 on MSB); 0: step k drives T[k].

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- EN  in  1  advance enable; step advances on a rising CLK edge when EN=1.
- CLR  in  1  synchronous restart to step 0 (end of instruction / branch flush).
- END_STEP  in  CNT_W  last step of the current instruction; the counter wraps after it.
- T  out  N_STEPS  one-hot timing lines.
- STEP  out  CNT_W  current step index (binary).
- LAST  out  1  high while the current step is the effective end step.
- WRAP  out  1  one-cycle registered pulse in the cycle after a wrap to step 0.

Behaviour:
- Reset:
  - On a CLK edge with RST=1: STEP=0 and WRAP=0.
  - T is the one-hot code of step 0: bit N_STEPS-1 if REVERSE=1, bit 0 otherwise.
  - RST overrides CLR and EN.
- Effective end:
  - eff_end = min(END_STEP, N_STEPS-1).
  - END_STEP is sampled every cycle; it is not latched.
- LAST is combinational: (STEP >= eff_end).
- Next-state priority, evaluated per edge:
  1. RST: STEP←0, WRAP←0.
  2. CLR: STEP←0, WRAP←0. CLR is not a wrap.
  3. EN=1 and LAST=1: STEP←0, WRAP←1.
  4. EN=1: STEP←STEP+1, WRAP←0.
  5. Otherwise: hold STEP, WRAP←0.
- Decode timing:
  - T is a pure combinational decode of registered STEP, with zero latency from STEP.
  - T is always exactly one-hot; STEP can never reach a value >= N_STEPS.
- END_STEP boundary cases:
  - END_STEP lowered below the current STEP mid-instruction: LAST=1 immediately, and the next enabled edge wraps to 0. The counter never runs past N_STEPS-1 or wraps through the binary range.
  - END_STEP=0: every enabled edge wraps; STEP stays 0 and WRAP pulses each enabled cycle.
- Stall: while EN=0, STEP, T and LAST hold, and WRAP is 0 after the first stalled edge.
- CLR and EN in the same cycle: CLR wins, with no WRAP.
- Throughput: one step per enabled cycle. Sequence length = eff_end+1 enabled cycles.

Decomposition:
- Shared control package holds:
  - the T-state index constants (T0..T31 as localparams);
  - REVERSE mapping helper constants, so control equations read identically for either ordering.
- One natural sub-module: onehot_decoder, parametrised width and REVERSE, combinational.
  - Out-of-range input gives all-zero, matching the legacy decoder's default.
  - Instantiated once by timing_sequencer.
- The counter and priority logic stay in the top module.

Test Plan:
1. Reset and T0 ordering:
   - N_STEPS=32, REVERSE=1, RST high 2 cycles then low with EN=0 → STEP=0, T=32'h8000_0000, LAST=0, WRAP=0.
   - Same with REVERSE=0 → T=32'h0000_0001.
2. Full-length sequence:
   - EN=1, END_STEP=31 → STEP counts 0..31 over 32 cycles with T one-hot each cycle.
   - LAST=1 only at step 31.
   - Step 0 follows, with WRAP=1 for exactly that cycle.
3. Short instruction and clamping:
   - END_STEP=3, EN=1 → steps 0,1,2,3,0,... with WRAP every 4th cycle.
   - N_STEPS=12, END_STEP=15 → wraps after step 11.
4. Stall and lowered end:
   - EN low 3 cycles at step 5 → STEP/T hold at 5.
   - Then END_STEP=2 with EN=1 → LAST=1 at once, next edge STEP=0, WRAP=1.
5. Priority:
   - CLR=1 with EN=1 and LAST=1 at step 7 → STEP=0, WRAP=0.
   - RST=1 with CLR=0, EN=1 mid-sequence → STEP=0 next edge.
6. Degenerate:
   - END_STEP=0, EN=1 for 4 cycles → STEP stays 0, WRAP=1 in each cycle after an enabled edge.
   - N_STEPS=2, REVERSE=1 → T alternates 2'b10/2'b01 with END_STEP=1.
